// File: rtl/risc_pkg.sv
// Shared definitions for the register-file write path: widths, register count
// and the queued write-entry layout.
package risc_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned SEL_WIDTH  = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// In-order write queue: DEPTH-entry synchronous FIFO exporting its entry array
// and per-slot valid bits so the owner can see every outstanding write.
module wq_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = risc_pkg::wr_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       entry_valid,
  output T                       entries [DEPTH]
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_off;

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_valid = '0;
    w_off       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off          = PW'(i) - r_rd_ptr;
      entry_valid[i] = ({1'b0, w_off} < r_count);
    end
  end

  assign head    = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign entries = r_mem;

endmodule

// File: rtl/reg_write_demux.sv
// Queued 1-to-8 register write demux: buffers (sel, data) requests and commits
// the head into one of eight registers, flagging registers with writes in flight.
module reg_write_demux #(
  parameter int unsigned          DATA_WIDTH  = risc_pkg::DATA_WIDTH,
  parameter int unsigned          DEPTH       = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [2:0]             wr_sel,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   drain_en,
  output logic [DATA_WIDTH-1:0]  out0,
  output logic [DATA_WIDTH-1:0]  out1,
  output logic [DATA_WIDTH-1:0]  out2,
  output logic [DATA_WIDTH-1:0]  out3,
  output logic [DATA_WIDTH-1:0]  out4,
  output logic [DATA_WIDTH-1:0]  out5,
  output logic [DATA_WIDTH-1:0]  out6,
  output logic [DATA_WIDTH-1:0]  out7,
  output logic [7:0]             pending,
  output logic [$clog2(DEPTH):0] count
);

  import risc_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                w_push_entry;
  entry_t                w_head;
  entry_t                w_entries [DEPTH];
  logic [DEPTH-1:0]      w_valid;
  logic [CW-1:0]         w_count;
  logic                  w_push;
  logic                  w_pop;
  logic [NUM_REGS-1:0]   w_wr_en;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Ready is derived from registered occupancy only, so a same-edge pop from a
  // full queue reopens it one cycle later.
  assign wr_ready     = (w_count < CW'(DEPTH)) && !reset;
  assign w_push       = wr_valid && wr_ready;
  assign w_pop        = drain_en && (w_count != '0);
  assign w_push_entry = '{sel: wr_sel, data: wr_data};

  wq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_wq_fifo (
    .clk         (clk),
    .rst         (reset),
    .push        (w_push),
    .push_data   (w_push_entry),
    .pop         (w_pop),
    .head        (w_head),
    .count       (w_count),
    .entry_valid (w_valid),
    .entries     (w_entries)
  );

  always_comb begin
    w_wr_en = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      w_wr_en[k] = w_pop && (w_head.sel == SEL_WIDTH'(k));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VALUE;
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (w_wr_en[k]) r_regs[k] <= w_head.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) pending[w_entries[i].sel] = 1'b1;
    end
  end

  assign count = w_count;
  assign out0  = r_regs[0];
  assign out1  = r_regs[1];
  assign out2  = r_regs[2];
  assign out3  = r_regs[3];
  assign out4  = r_regs[4];
  assign out5  = r_regs[5];
  assign out6  = r_regs[6];
  assign out7  = r_regs[7];

endmodule

// File: tb/tb_reg_write_demux.sv
// Scoreboard bench for reg_write_demux: accepted writes are queued in a model
// and popped into a reference register file when the model predicts a commit.
module tb_reg_write_demux;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic       drain_en;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0] pending;
  logic [1:0] count;

  ent_t       q[$];
  logic [7:0] exp_regs [8];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  reg_write_demux #(
    .DATA_WIDTH  (8),
    .DEPTH       (DEPTH),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .drain_en (drain_en),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out5     (out5),
    .out6     (out6),
    .out7     (out7),
    .pending  (pending),
    .count    (count)
  );

  function automatic logic [7:0] dut_out(input int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      3: return out3;
      4: return out4;
      5: return out5;
      6: return out6;
      default: return out7;
    endcase
  endfunction

  function automatic logic [7:0] exp_pending();
    logic [7:0] p;
    p = '0;
    foreach (q[i]) p[q[i].sel] = 1'b1;
    return p;
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, return #1 after it.
  task automatic step(input logic v, input logic [2:0] s, input logic [7:0] d, input logic dr);
    bit   m_commit;
    bit   m_accept;
    ent_t e;
    wr_valid = v;
    wr_sel   = s;
    wr_data  = d;
    drain_en = dr;
    @(posedge clk);
    m_commit = dr && (q.size() != 0);
    m_accept = v && (q.size() < DEPTH);
    if (m_commit) begin
      e = q.pop_front();
      exp_regs[e.sel] = e.data;
    end
    if (m_accept) q.push_back('{sel: s, data: d});
    #1;
    wr_valid = 1'b0;
    drain_en = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    drain_en = 1'b0;
    foreach (exp_regs[k]) exp_regs[k] = 8'h00;
    #3;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", wr_ready); end
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", wr_ready); end

    // Mid-stream reset with a committed register and a full queue.
    step(1'b1, 3'd1, 8'h77, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    n_checks++;
    if (out1 !== exp_regs[1]) begin n_fail++; $display("FAIL pre_reset_out1: got %h expected %h", out1, exp_regs[1]); end
    step(1'b1, 3'd2, 8'h12, 1'b0);
    step(1'b1, 3'd6, 8'h34, 1'b0);
    n_checks++;
    if (count !== 2'd2) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 2", count); end
    #2 reset = 1'b1;
    #1;
    q.delete();
    foreach (exp_regs[k]) exp_regs[k] = 8'h00;
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", count); end
    n_checks++;
    if (pending !== 8'h00) begin n_fail++; $display("FAIL async_reset_pending: got %h expected 00", pending); end
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 0", wr_ready); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (dut_out(k) !== 8'h00) begin n_fail++; $display("FAIL async_reset_out%0d: got %h expected 00", k, dut_out(k)); end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL held_reset_ready: got %b expected 0", wr_ready); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL after_release_ready: got %b expected 1", wr_ready); end
  endtask

  task automatic test_seq_fill();
    logic [7:0] vals [8];
    vals = '{8'hAA, 8'h0F, 8'hF0, 8'h55, 8'hE3, 8'h33, 8'hCC, 8'h1C};
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3'(k), vals[k], 1'b1);
      n_checks++;
      if (count !== 2'(q.size())) begin n_fail++; $display("FAIL fill_count_%0d: got %0d expected %0d", k, count, q.size()); end
      n_checks++;
      if (pending !== exp_pending()) begin n_fail++; $display("FAIL fill_pending_%0d: got %h expected %h", k, pending, exp_pending()); end
      n_checks++;
      if ($countones(pending) > 2) begin n_fail++; $display("FAIL fill_pending_bits_%0d: got %h expected at most 2 bits", k, pending); end
      if (k > 0) begin
        n_checks++;
        if (dut_out(k - 1) !== vals[k - 1]) begin
          n_fail++; $display("FAIL fill_out%0d: got %h expected %h", k - 1, dut_out(k - 1), vals[k - 1]);
        end
      end
    end
    step(1'b0, 3'd0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (dut_out(k) !== exp_regs[k]) begin n_fail++; $display("FAIL fill_final_out%0d: got %h expected %h", k, dut_out(k), exp_regs[k]); end
    end
    n_checks++;
    if (out7 !== 8'h1C) begin n_fail++; $display("FAIL fill_out7: got %h expected 1c", out7); end
  endtask

  task automatic test_full();
    step(1'b1, 3'd0, 8'h10, 1'b0);
    step(1'b1, 3'd1, 8'h20, 1'b0);
    step(1'b1, 3'd2, 8'h30, 1'b0);
    n_checks++;
    if (count !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d expected 2", count); end
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", wr_ready); end
    n_checks++;
    if (pending !== 8'h03) begin n_fail++; $display("FAIL full_pending: got %h expected 03", pending); end
    step(1'b1, 3'd2, 8'h30, 1'b1);
    n_checks++;
    if (count !== 2'd1) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 1", count); end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen_ready: got %b expected 1", wr_ready); end
    n_checks++;
    if (out0 !== 8'h10) begin n_fail++; $display("FAIL full_out0: got %h expected 10", out0); end
    step(1'b1, 3'd2, 8'h30, 1'b0);
    n_checks++;
    if (count !== 2'd2) begin n_fail++; $display("FAIL full_third_count: got %0d expected 2", count); end
    n_checks++;
    if (pending !== exp_pending()) begin n_fail++; $display("FAIL full_third_pending: got %h expected %h", pending, exp_pending()); end
    step(1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    n_checks++;
    if (out1 !== exp_regs[1]) begin n_fail++; $display("FAIL full_out1: got %h expected %h", out1, exp_regs[1]); end
    n_checks++;
    if (out2 !== 8'h30) begin n_fail++; $display("FAIL full_out2: got %h expected 30", out2); end
  endtask

  task automatic test_same_dest();
    step(1'b1, 3'd3, 8'h11, 1'b0);
    step(1'b1, 3'd3, 8'h22, 1'b0);
    n_checks++;
    if (pending !== 8'h08) begin n_fail++; $display("FAIL same_pending_queued: got %h expected 08", pending); end
    step(1'b0, 3'd0, 8'h00, 1'b1);
    n_checks++;
    if (out3 !== 8'h11) begin n_fail++; $display("FAIL same_first_out3: got %h expected 11", out3); end
    n_checks++;
    if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL same_pending_mid: got %b expected 1", pending[3]); end
    step(1'b0, 3'd0, 8'h00, 1'b1);
    n_checks++;
    if (out3 !== 8'h22) begin n_fail++; $display("FAIL same_second_out3: got %h expected 22", out3); end
    n_checks++;
    if (pending !== 8'h00) begin n_fail++; $display("FAIL same_pending_done: got %h expected 00", pending); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 3'd4, 8'h41, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] prev_sel;
      logic [2:0] s;
      logic [7:0] d;
      prev_sel = q[0].sel;
      s = 3'((i * 3 + 5) % 8);
      d = 8'($urandom_range(0, 255));
      step(1'b1, s, d, 1'b1);
      n_checks++;
      if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d expected 1", i, count); end
      n_checks++;
      if (dut_out(int'(prev_sel)) !== exp_regs[prev_sel]) begin
        n_fail++; $display("FAIL b2b_out%0d_%0d: got %h expected %h", prev_sel, i, dut_out(int'(prev_sel)), exp_regs[prev_sel]);
      end
      n_checks++;
      if (pending !== exp_pending()) begin n_fail++; $display("FAIL b2b_pending_%0d: got %h expected %h", i, pending, exp_pending()); end
    end
    step(1'b0, 3'd0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (dut_out(k) !== exp_regs[k]) begin n_fail++; $display("FAIL b2b_final_out%0d: got %h expected %h", k, dut_out(k), exp_regs[k]); end
    end
  endtask

  task automatic test_empty_drain();
    logic [7:0] before5;
    before5 = exp_regs[5];
    step(1'b0, 3'd0, 8'h00, 1'b1);
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL empty_drain_count: got %0d expected 0", count); end
    step(1'b1, 3'd5, 8'h5A, 1'b1);
    n_checks++;
    if (count !== 2'd1) begin n_fail++; $display("FAIL nobypass_count: got %0d expected 1", count); end
    n_checks++;
    if (out5 !== before5) begin n_fail++; $display("FAIL nobypass_out5: got %h expected %h", out5, before5); end
    n_checks++;
    if (pending !== 8'h20) begin n_fail++; $display("FAIL nobypass_pending: got %h expected 20", pending); end
    step(1'b0, 3'd0, 8'h00, 1'b1);
    n_checks++;
    if (out5 !== 8'h5A) begin n_fail++; $display("FAIL nobypass_commit_out5: got %h expected 5a", out5); end
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL nobypass_final_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_seq_fill();
    test_full();
    test_same_dest();
    test_back_to_back();
    test_empty_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_demux.md
# reg_write_demux

Write-side counterpart to the register-select multiplexer: takes a stream of (destination select, data) write requests, buffers them in a small in-order queue, and commits each one into exactly one of eight 8-bit registers. The eight register outputs feed the 8:1 read multiplexer's data inputs directly. A per-register pending mask tells the read side which registers still have a queued write outstanding.

## Interface
Parameters:
- DATA_WIDTH, 8, register and write-data width
- DEPTH, 2, write-queue entries (power of two, ≥2)
- RESET_VALUE, 0, value loaded into every register on reset

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- wr_valid  in  1  write request present
- wr_ready  out  1  queue can accept this cycle
- wr_sel  in  3  destination register index 0..7
- wr_data  in  DATA_WIDTH  write data
- drain_en  in  1  permits the queue head to commit this cycle
- out0..out7  out  DATA_WIDTH each  current register contents (to read mux in0..in7)
- pending  out  8  bit i = 1 while any queued entry targets register i
- count  out  $clog2(DEPTH)+1  number of queued entries

## Operation
- Accept: wr_valid && wr_ready at an edge pushes {wr_sel, wr_data} at the tail. wr_data and wr_sel are sampled only on accept.
- wr_ready = (count < DEPTH) && !reset. Combinational from count; never depends on wr_valid or drain_en.
- Commit: drain_en && count != 0 at an edge pops the head and writes its data into register[head.sel]. All other registers hold.
- Occupancy states EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH):
  - accept only → count+1
  - commit only → count-1
  - both → count unchanged
  - neither → hold
- Full: wr_ready = 0. Same-cycle commit does not reopen wr_ready; it rises the following cycle.
- Empty with wr_valid && drain_en: no bypass. The entry is queued and commits at the earliest on the next edge.
- Same destination queued twice: commits happen in order. The register ends at the later value. The pending bit stays set until the last such entry commits.
- pending: recomputed combinationally from the valid queue entries. A bit clears in the cycle after the commit of the last entry targeting that register.
- Pointers wrap modulo DEPTH.
- drain_en while empty: no effect.
- wr_valid while full: no effect; the requester must hold the request.
- Reset, asynchronous, including mid-operation:
  - out0..out7 = RESET_VALUE
  - count = 0, pending = 0
  - queue contents discarded
  - wr_ready = 0 while reset is asserted, 1 in the first cycle after release

## Timing
- Latency: accepted at edge N → earliest commit at edge N+1 → new value visible on outK after edge N+1.
- Throughput: one accept and one commit per cycle sustained, provided count < DEPTH.
- out0..out7, count, and the queue are registered. wr_ready and pending are combinational from registered state only, with no input→output combinational path.

## Structure
- Shared package risc_pkg holds: DATA_WIDTH, SEL_WIDTH = 3, NUM_REGS = 8, and a write-entry type {sel, data}.
- Sub-module wq_fifo: DEPTH-entry synchronous FIFO with push/pop/count, entry-valid vector, and an entry array export used for the pending computation.
- The top level holds the 1-to-8 write decode, the eight registers, and the pending OR-reduction.

## Test plan
- Reset value: assert reset mid-stream with count = 2 → out0..out7 = 0x00, count = 0, pending = 0x00, wr_ready = 0 during reset and 1 the cycle after release.
- Sequential fill: write sel 0..7 with data 0xAA, 0x0F, 0xF0, 0x55, 0xE3, 0x33, 0xCC, 0x1C, drain_en held high → each outK shows its value one edge after accept; pending never exceeds 2 bits set.
- Full back-pressure: drain_en = 0, offer three writes → first two accepted, count = 2, wr_ready = 0, third held. Raise drain_en for one cycle → count = 1, wr_ready = 1 the next cycle, third accepted.
- Same-destination ordering: queue sel 3 with 0x11, then sel 3 with 0x22, then drain → out3 = 0x11, then 0x22. pending[3] stays 1 until after the second commit.
- Simultaneous accept and commit at count = 1 → count stays 1, head register updated, new entry retained. Pointer wrap exercised across ≥2·DEPTH operations.
- Drain on empty plus no-bypass: count = 0, wr_valid = 1, drain_en = 1 for one edge → registers unchanged at that edge, count = 1. Commit occurs on the next edge with drain_en = 1.
